tx_frame_sequencer: RTL and testbench
=====================================

# tx_frame_sequencer

Ping-pong frame scheduler for the TX sample RAM. It tracks two frame banks and grants the AXIS loader a free bank to fill. It sequences playback of full banks to the I/Q mapper by generating read addresses, the playback-active flag and a frame sequence number. After every played frame it returns one status byte to the processor over an AXI-Stream master.

## Interface
Parameters:
- ADDR_W, 10, read address width per bank
- FRAME_LEN, 1024, samples per frame (2..2^ADDR_W)
- SEQ_W, 4, sequence counter width (≤4)
- GAP_CYCLES, 16, idle cycles between frames (≥1)

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-low reset
- load_done  in  1  one-cycle pulse: loader accepted tlast into bank wr_bank
- dac_ready  in  1  downstream consumes one sample this cycle
- halt  in  1  level: stop after current frame, do not start new frames
- wr_bank  out  1  bank the loader must fill
- wr_enable  out  1  loader may accept AXIS data (bank wr_bank empty)
- rd_bank  out  1  bank being played
- rd_addr  out  ADDR_W  sample address within rd_bank
- rd_valid  out  1  rd_addr is a live read this cycle
- pl_ready  out  1  playback active (high in PLAY)
- seq_num  out  SEQ_W  number of frame in/last in playback
- stat_data  out  8  status byte
- stat_valid  out  1  status byte valid
- stat_keep  out  1  byte keep, equal to stat_valid
- stat_tlast  out  1  equal to stat_valid (one-byte packets)
- stat_ready  in  1  processor DMA accepts byte

## Operation
- State: bank_full[1:0], wr_bank, rd_bank, sticky underrun, sticky overflow, reader FSM {IDLE, PLAY, REPORT, GAP}.
- Writer side: wr_enable = ~bank_full[wr_bank] (combinational from registers). On load_done with wr_enable: set bank_full[wr_bank], toggle wr_bank. On load_done with bank full: no flag change, set overflow.
- IDLE: if bank_full[rd_bank] && !halt → PLAY, rd_addr=0.
- PLAY: pl_ready=1; rd_valid = dac_ready; on dac_ready, rd_addr+1. When rd_addr==FRAME_LEN-1 and dac_ready: clear bank_full[rd_bank], toggle rd_bank, → REPORT. halt does not abort PLAY.
- REPORT: stat_valid=1, stat_data={seq_num[3:0] zero-extended, underrun, overflow, bank just played, halt}, MSB→LSB [7:4],[3],[2],[1],[0]. Data stays stable until stat_ready. On accept: seq_num+1 (wraps modulo 2^SEQ_W), clear underrun/overflow unless re-set that same cycle, → GAP.
- GAP: count GAP_CYCLES cycles, then: bank_full[rd_bank] && !halt → PLAY; else → IDLE, and if !halt set underrun.
- Simultaneous load_done and bank clear in the same cycle both apply. They always target different banks or the same bank after clear. If they target the same bank, the set wins and the bank ends full.

## Timing
- Reset (async assert, sync release): FSM=IDLE, bank_full=0, wr_bank=0, rd_bank=0, rd_addr=0, rd_valid=0, pl_ready=0, seq_num=0, stat_valid=0, stat_data=0, flags=0. wr_enable=1.
- Reset mid-frame discards all banks and the pending status byte immediately.
- load_done → wr_enable reflects new bank one cycle later. IDLE → PLAY 1 cycle after bank_full seen; first rd_valid in the first PLAY cycle with rd_addr=0.
- rd_addr/rd_valid registered-state outputs; RAM read latency is downstream's concern.
- Frame length in PLAY = exactly FRAME_LEN dac_ready cycles. Last-sample cycle → REPORT next cycle.
- AXIS: stat_valid never drops without stat_ready; stalls of any length are legal. Frame-to-frame minimum spacing = 1 (REPORT) + GAP_CYCLES cycles.

## Test plan
- Reset, single load_done (bank 0), dac_ready=1, FRAME_LEN=8 → rd_addr 0..7 on 8 consecutive cycles, then stat_data=0x00 once. Then underrun set after GAP, reported next frame as bit3.
- Both banks loaded, dac_ready=1, stat_ready=1 → frames bank0 then bank1, seq_num 0 then 1. Status bytes 0x00, 0x12, no underrun, gap exactly 1+GAP_CYCLES cycles.
- dac_ready toggling 50% → rd_addr advances only on high cycles, frame ends after 8 high cycles, rd_valid==dac_ready in PLAY.
- Third load_done while both banks full → wr_enable=0, no bank change, next status byte has bit2=1; following byte bit2=0.
- stat_ready held low 20 cycles in REPORT → stat_data stable, seq_num unchanged until accept. 16 frames wrap seq_num 15→0.
- halt asserted mid-PLAY with other bank full → frame completes, REPORT bit0=1, FSM→IDLE, no underrun. Async reset mid-PLAY → all outputs to reset values same cycle.

Source files
------------

// File: rtl/tx_frame_sequencer.sv
// rtl/tx_frame_sequencer.sv - ping-pong TX frame bank scheduler with per-frame status byte
module tx_frame_sequencer #(
  parameter int ADDR_W     = 10,
  parameter int FRAME_LEN  = 1024,
  parameter int SEQ_W      = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_done,
  input  logic              dac_ready,
  input  logic              halt,
  output logic              wr_bank,
  output logic              wr_enable,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic              pl_ready,
  output logic [SEQ_W-1:0]  seq_num,
  output logic [7:0]        stat_data,
  output logic              stat_valid,
  output logic              stat_keep,
  output logic              stat_tlast,
  input  logic              stat_ready
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_REPORT = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'(GAP_CYCLES - 1);

  state_t              state_q;
  state_t              state_d;
  logic [1:0]          bank_full_q;
  logic [1:0]          bank_full_d;
  logic                wr_bank_q;
  logic                rd_bank_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [GAP_W-1:0]    gap_cnt_q;
  logic [SEQ_W-1:0]    seq_q;
  logic                underrun_q;
  logic                overflow_q;
  logic [7:0]          stat_data_q;
  logic                set_underrun;

  logic                load_ok;
  logic                load_ovf;
  logic                last_sample;
  logic                stat_accept;
  logic                gap_done;
  logic                next_ready;
  logic [3:0]          seq_ext;

  assign wr_enable   = ~bank_full_q[wr_bank_q];
  assign load_ok     = load_done & wr_enable;
  assign load_ovf    = load_done & ~wr_enable;
  assign last_sample = (state_q == ST_PLAY) && dac_ready && (rd_addr_q == LAST_ADDR);
  assign stat_accept = (state_q == ST_REPORT) && stat_ready;
  assign gap_done    = (state_q == ST_GAP) && (gap_cnt_q == LAST_GAP);
  assign next_ready  = bank_full_q[rd_bank_q] && !halt;
  assign seq_ext     = 4'(seq_q);

  // Reader FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Reader FSM next-state; an empty bank at the end of a gap is an underrun unless halted
  always_comb begin
    state_d      = state_q;
    set_underrun = 1'b0;
    case (state_q)
      ST_IDLE:   if (next_ready) state_d = ST_PLAY;
      ST_PLAY:   if (last_sample) state_d = ST_REPORT;
      ST_REPORT: if (stat_ready) state_d = ST_GAP;
      ST_GAP: begin
        if (gap_done) begin
          if (next_ready) begin
            state_d = ST_PLAY;
          end else begin
            state_d      = ST_IDLE;
            set_underrun = !halt;
          end
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Bank occupancy: clear of the played bank first, so a same-bank load still leaves it full
  always_comb begin
    bank_full_d = bank_full_q;
    if (last_sample) bank_full_d[rd_bank_q] = 1'b0;
    if (load_ok)     bank_full_d[wr_bank_q] = 1'b1;
  end

  // Bank pointers, read address, gap timer, sequence number, sticky flags and status snapshot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_full_q <= 2'b00;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_addr_q   <= '0;
      gap_cnt_q   <= '0;
      seq_q       <= '0;
      underrun_q  <= 1'b0;
      overflow_q  <= 1'b0;
      stat_data_q <= 8'h00;
    end else begin
      bank_full_q <= bank_full_d;
      if (load_ok) wr_bank_q <= ~wr_bank_q;
      if (last_sample) rd_bank_q <= ~rd_bank_q;

      if ((state_q == ST_PLAY) && dac_ready) begin
        rd_addr_q <= last_sample ? '0 : rd_addr_q + ADDR_W'(1);
      end

      gap_cnt_q <= ((state_q == ST_GAP) && !gap_done) ? gap_cnt_q + GAP_W'(1) : '0;

      if (stat_accept) seq_q <= seq_q + SEQ_W'(1);

      if (stat_accept)       underrun_q <= 1'b0;
      else if (set_underrun) underrun_q <= 1'b1;

      if (stat_accept)   overflow_q <= load_ovf;
      else if (load_ovf) overflow_q <= 1'b1;

      // Snapshot keeps the byte stable for the whole REPORT stall
      if (last_sample) begin
        stat_data_q <= {seq_ext, underrun_q, overflow_q | load_ovf, rd_bank_q, halt};
      end
    end
  end

  assign wr_bank    = wr_bank_q;
  assign rd_bank    = rd_bank_q;
  assign rd_addr    = rd_addr_q;
  assign rd_valid   = (state_q == ST_PLAY) && dac_ready;
  assign pl_ready   = (state_q == ST_PLAY);
  assign seq_num    = seq_q;
  assign stat_data  = stat_data_q;
  assign stat_valid = (state_q == ST_REPORT);
  assign stat_keep  = stat_valid;
  assign stat_tlast = stat_valid;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// tb/tb_tx_frame_sequencer.sv - randomized and directed bench for tx_frame_sequencer
module tb_tx_frame_sequencer;

  localparam int AW  = 3;
  localparam int FL  = 8;
  localparam int SW  = 4;
  localparam int GAP = 3;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_REP  = 2;
  localparam int M_GAP  = 3;

  logic          clk;
  logic          reset;
  logic          load_done;
  logic          dac_ready;
  logic          halt;
  logic          wr_bank;
  logic          wr_enable;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic          pl_ready;
  logic [SW-1:0] seq_num;
  logic [7:0]    stat_data;
  logic          stat_valid;
  logic          stat_keep;
  logic          stat_tlast;
  logic          stat_ready;

  tx_frame_sequencer #(
    .ADDR_W(AW), .FRAME_LEN(FL), .SEQ_W(SW), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset(reset), .load_done(load_done), .dac_ready(dac_ready), .halt(halt),
    .wr_bank(wr_bank), .wr_enable(wr_enable), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .pl_ready(pl_ready), .seq_num(seq_num), .stat_data(stat_data),
    .stat_valid(stat_valid), .stat_keep(stat_keep), .stat_tlast(stat_tlast),
    .stat_ready(stat_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit prev_pl = 1'b0;
  int got_q[$];
  int rv_q[$];
  int play_starts[$];

  // reference model: frame-level bookkeeping with a samples-left countdown
  bit mf[2];
  int mwb, mrb, mund, movf, mseq, mmode, mleft, mgap, mbyte;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int byte_at(int i);
    return (got_q.size() > i) ? got_q[i] : -1;
  endfunction

  function automatic int addr_at(int i);
    return (rv_q.size() > i) ? rv_q[i] : -1;
  endfunction

  task automatic m_reset();
    mf[0] = 0; mf[1] = 0;
    mwb = 0; mrb = 0; mund = 0; movf = 0; mseq = 0;
    mmode = M_IDLE; mleft = 0; mgap = 0; mbyte = 0;
  endtask

  task automatic m_step(input bit ld, input bit dac, input bit hlt, input bit srdy);
    bit full_rd, full_wr, ovf_evt, load_evt, frame_end, accept;
    full_rd   = mf[mrb];
    full_wr   = mf[mwb];
    ovf_evt   = ld && full_wr;
    load_evt  = ld && !full_wr;
    frame_end = (mmode == M_PLAY) && dac && (mleft == 1);
    accept    = (mmode == M_REP) && srdy;
    case (mmode)
      M_IDLE: if (full_rd && !hlt) begin mmode = M_PLAY; mleft = FL; end
      M_PLAY: if (dac) begin
        mleft = mleft - 1;
        if (mleft == 0) begin
          mbyte = (mseq % 16) * 16 + mund * 8 + (movf | ovf_evt) * 4 + mrb * 2 + hlt;
          mmode = M_REP;
        end
      end
      M_REP: if (srdy) begin
        mseq  = (mseq + 1) % 16;
        mund  = 0;
        mmode = M_GAP;
        mgap  = GAP;
      end
      default: begin
        mgap = mgap - 1;
        if (mgap == 0) begin
          if (full_rd && !hlt) begin
            mmode = M_PLAY; mleft = FL;
          end else begin
            mmode = M_IDLE;
            if (!hlt) mund = 1;
          end
        end
      end
    endcase
    if (accept) movf = ovf_evt;
    else        movf = movf | ovf_evt;
    if (frame_end) begin mf[mrb] = 0; mrb = 1 - mrb; end
    if (load_evt)  begin mf[mwb] = 1; mwb = 1 - mwb; end
  endtask

  task automatic compare_outputs();
    check("wr_bank",    wr_bank,    mwb);
    check("wr_enable",  wr_enable,  !mf[mwb]);
    check("rd_bank",    rd_bank,    mrb);
    check("rd_addr",    rd_addr,    (mmode == M_PLAY) ? FL - mleft : 0);
    check("rd_valid",   rd_valid,   (mmode == M_PLAY) && dac_ready);
    check("pl_ready",   pl_ready,   mmode == M_PLAY);
    check("seq_num",    seq_num,    mseq);
    check("stat_valid", stat_valid, mmode == M_REP);
    check("stat_data",  stat_data,  mbyte);
    check("stat_keep",  stat_keep,  mmode == M_REP);
    check("stat_tlast", stat_tlast, mmode == M_REP);
  endtask

  task automatic cycle(input bit ld, input bit dac, input bit hlt, input bit srdy);
    load_done = ld; dac_ready = dac; halt = hlt; stat_ready = srdy;
    #1;
    compare_outputs();
    if (pl_ready && !prev_pl) play_starts.push_back(cyc);
    prev_pl = pl_ready;
    if (rd_valid) rv_q.push_back(int'(rd_addr));
    if (stat_valid && stat_ready) got_q.push_back(int'(stat_data));
    m_step(ld, dac, hlt, srdy);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic async_reset();
    load_done = 0; dac_ready = 0; halt = 0; stat_ready = 0;
    #2;
    reset = 1'b0;
    #1;
    m_reset();
    compare_outputs();
    check("arst_pl_ready",  pl_ready,   0);
    check("arst_rd_addr",   rd_addr,    0);
    check("arst_stat_vld",  stat_valid, 0);
    check("arst_wr_enable", wr_enable,  1);
    prev_pl = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc++;
  endtask

  initial begin
    int c0;
    bit hr;
    reset = 1'b0; load_done = 0; dac_ready = 0; halt = 0; stat_ready = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_enable", wr_enable,  1);
    check("rst_wr_bank",   wr_bank,    0);
    check("rst_pl_ready",  pl_ready,   0);
    check("rst_stat_data", stat_data,  0);
    check("rst_seq_num",   seq_num,    0);
    reset = 1'b1;

    // single bank, then underrun reported with the next frame
    c0 = cyc;
    cycle(1, 1, 0, 1);
    repeat (29) cycle(0, 1, 0, 1);
    check("a_play_start", (play_starts.size() > 0) ? play_starts[0] : -1, c0 + 2);
    check("a_nsamples", rv_q.size(), FL);
    for (int i = 0; i < FL; i++) check("a_addr_seq", addr_at(i), i);
    check("a_byte0", byte_at(0), 8'h00);
    cycle(1, 1, 0, 1);
    repeat (29) cycle(0, 1, 0, 1);
    check("a_byte1_underrun", byte_at(1), 8'h1A);

    // both banks plus an overflowing third load; back-to-back spacing
    got_q.delete(); play_starts.delete();
    cycle(1, 1, 0, 1);
    cycle(1, 1, 0, 1);
    cycle(1, 1, 0, 1);
    check("b_wr_enable_full", wr_enable, 0);
    check("b_wr_bank_kept",   wr_bank,   0);
    repeat (40) cycle(0, 1, 0, 1);
    check("b_byte0_ovf", byte_at(0), 8'h2C);
    check("b_byte1",     byte_at(1), 8'h32);
    check("b_spacing", (play_starts.size() > 1) ? play_starts[1] - play_starts[0] : -1, FL + 1 + GAP);

    // halt mid-frame with the other bank full
    got_q.delete(); play_starts.delete();
    cycle(1, 1, 0, 1);
    cycle(1, 1, 0, 1);
    repeat (3) cycle(0, 1, 0, 1);
    repeat (40) cycle(0, 1, 1, 1);
    check("c_byte_halt", byte_at(0), 8'h49);
    check("c_no_restart", play_starts.size(), 1);
    check("c_idle", pl_ready, 0);
    repeat (30) cycle(0, 1, 0, 1);
    check("c_byte_after_halt", byte_at(1), 8'h52);

    // status stall of 20 cycles
    cycle(1, 1, 0, 1);
    hr = 1'b0;
    for (int i = 0; i < 40 && !hr; i++) begin
      cycle(0, 1, 0, 0);
      hr = stat_valid;
    end
    check("d_reach_report", hr, 1);
    repeat (20) begin
      cycle(0, 1, 0, 0);
      check("d_hold_data", stat_data, 8'h68);
      check("d_hold_seq",  seq_num,   6);
    end
    cycle(0, 1, 0, 1);
    check("d_seq_after", seq_num, 7);

    // asynchronous reset in the middle of a frame
    repeat (5) cycle(0, 1, 0, 1);
    cycle(1, 1, 0, 1);
    repeat (5) cycle(0, 1, 0, 1);
    check("e_in_play", pl_ready, 1);
    async_reset();

    // randomized traffic against the model
    hr = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        async_reset();
      end else begin
        if ($urandom_range(0, 59) == 0) hr = !hr;
        cycle($urandom_range(0, 6) == 0, $urandom_range(0, 3) != 0, hr,
              $urandom_range(0, 2) != 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
